// File: rtl/gfx_cmd_dispatch.sv
// Graphics command dispatcher.
// Pops command words from a first-word-fall-through FIFO, decodes them,
// programs the frame base address and hands one fill request per FILL command
// to the frame filler over a valid/ready handshake. Processing runs from a
// start pulse until a STOP command.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start; counters hold their last values
// S_FETCH   | decode the FIFO head word (stall while the FIFO is empty)
// S_BASE    | next FIFO word is raw frame base data, not an opcode
// S_ISSUE   | present the fill request once the filler reports ready
// S_WAIT_LO | request sent; wait for ready to drop (filler accepted)
// S_WAIT_HI | filler busy; wait for ready to return (fill complete)

module gfx_cmd_dispatch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cmd_empty,
    input  logic [31:0] cmd_dout,
    output logic        cmd_rd_en,
    input  logic        ff_ready,
    output logic        ff_valid,
    output logic [23:0] ff_color,
    output logic [31:0] ff_frame_base,
    output logic        busy,
    output logic        done,
    output logic [15:0] fill_count,
    output logic [7:0]  err_count
);

    localparam logic [7:0] OP_STOP    = 8'h00;
    localparam logic [7:0] OP_FILL    = 8'h01;
    localparam logic [7:0] OP_SETBASE = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BASE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  opcode;
    logic        clr_counts;
    logic        latch_color;
    logic        latch_base;
    logic        fill_inc;
    logic        err_inc;

    assign opcode = cmd_dout[31:24];
    assign busy   = (state != S_IDLE);

    // State register; reset abandons any filler handshake in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the combinational strobes (pop, fill request, done).
    always_comb begin
        state_nxt   = state;
        cmd_rd_en   = 1'b0;
        ff_valid    = 1'b0;
        done        = 1'b0;
        clr_counts  = 1'b0;
        latch_color = 1'b0;
        latch_base  = 1'b0;
        fill_inc    = 1'b0;
        err_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clr_counts = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!cmd_empty) begin
                    cmd_rd_en = 1'b1;
                    case (opcode)
                        OP_STOP: begin
                            done      = 1'b1;
                            state_nxt = S_IDLE;
                        end
                        OP_FILL: begin
                            latch_color = 1'b1;
                            state_nxt   = S_ISSUE;
                        end
                        OP_SETBASE: begin
                            state_nxt = S_BASE;
                        end
                        default: begin
                            err_inc = 1'b1;
                        end
                    endcase
                end
            end
            S_BASE: begin
                if (!cmd_empty) begin
                    cmd_rd_en  = 1'b1;
                    latch_base = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_ISSUE: begin
                // The request is only strobed while the filler is idle, so a
                // single-cycle valid is always seen by the filler.
                if (ff_ready) begin
                    ff_valid  = 1'b1;
                    fill_inc  = 1'b1;
                    state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!ff_ready) begin
                    state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (ff_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Fill color and frame base; base only moves in S_BASE, never mid-fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ff_color      <= 24'h0;
            ff_frame_base <= 32'h0;
        end else begin
            if (latch_color) begin
                ff_color <= cmd_dout[23:0];
            end
            if (latch_base) begin
                ff_frame_base <= cmd_dout;
            end
        end
    end

    // Status counters: fills wrap, unknown-opcode errors saturate at 255.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_count <= 16'h0;
            err_count  <= 8'h0;
        end else if (clr_counts) begin
            fill_count <= 16'h0;
            err_count  <= 8'h0;
        end else begin
            if (fill_inc) begin
                fill_count <= fill_count + 16'd1;
            end
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gfx_cmd_dispatch.sv
// Self-checking bench for gfx_cmd_dispatch: FIFO and filler models, a fill
// scoreboard and a done scoreboard checked by an independent monitor.

module tb_gfx_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cmd_empty;
    logic [31:0] cmd_dout;
    logic        cmd_rd_en;
    logic        ff_ready;
    logic        ff_valid;
    logic [23:0] ff_color;
    logic [31:0] ff_frame_base;
    logic        busy;
    logic        done;
    logic [15:0] fill_count;
    logic [7:0]  err_count;

    gfx_cmd_dispatch dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cmd_empty     (cmd_empty),
        .cmd_dout      (cmd_dout),
        .cmd_rd_en     (cmd_rd_en),
        .ff_ready      (ff_ready),
        .ff_valid      (ff_valid),
        .ff_color      (ff_color),
        .ff_frame_base (ff_frame_base),
        .busy          (busy),
        .done          (done),
        .fill_count    (fill_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] color;
        logic [31:0] base;
        int          lat;
    } fill_exp_t;

    typedef struct {
        logic [15:0] fc;
        logic [7:0]  ec;
    } done_exp_t;

    fill_exp_t   sb[$];
    done_exp_t   dq[$];
    logic [31:0] fifo_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pop_count   = 0;
    int valid_count = 0;
    int done_count  = 0;
    int fill_pop_cyc = 0;
    int low_left    = 0;
    bit rd_s        = 1'b0;
    bit valid_s     = 1'b0;
    bit stall_req   = 1'b0;
    bit stall_used  = 1'b0;
    bit busy_drop_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO and filler environment: updates just after each rising edge.
    initial begin
        logic [31:0] popped;
        bit          trig_stall;
        ff_ready  = 1'b1;
        cmd_empty = 1'b1;
        cmd_dout  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            trig_stall = 1'b0;
            if (rd_s && fifo_q.size() > 0) begin
                popped = fifo_q.pop_front();
                pop_count++;
                if (popped[31:24] == 8'h01 && stall_req && !stall_used) begin
                    trig_stall = 1'b1;
                    stall_used = 1'b1;
                end
            end
            if (valid_s) begin
                ff_ready = 1'b0;
                low_left = 19;
            end else if (trig_stall) begin
                ff_ready = 1'b0;
                low_left = 4;
            end else if (low_left > 0) begin
                low_left--;
            end else begin
                ff_ready = 1'b1;
            end
            #1;
            cmd_empty = (fifo_q.size() == 0);
            cmd_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        end
    end

    // Monitor: samples on the falling edge and checks against the scoreboards.
    always @(negedge clk) begin
        fill_exp_t fe;
        done_exp_t de;
        rd_s    = cmd_rd_en;
        valid_s = ff_valid;
        if (cmd_rd_en) begin
            check("pop_while_empty", 32'(cmd_empty), 32'd0);
            if (cmd_dout[31:24] == 8'h01) fill_pop_cyc = cyc;
        end
        if (ff_valid) begin
            valid_count++;
            check("valid_while_not_ready", 32'(ff_ready), 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ff_valid: got color 0x%0h, expected no request (cycle %0d)", ff_color, cyc);
            end else begin
                fe = sb.pop_front();
                check("ff_color", 32'(ff_color), 32'(fe.color));
                check("ff_frame_base", ff_frame_base, fe.base);
                check("fill_latency", 32'(cyc - fill_pop_cyc), 32'(fe.lat));
            end
        end
        if (busy_drop_chk) begin
            check("busy_after_done", 32'(busy), 32'd0);
            busy_drop_chk = 1'b0;
        end
        if (done) begin
            done_count++;
            if (dq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
                de = dq.pop_front();
                check("done_fill_count", 32'(fill_count), 32'(de.fc));
                check("done_err_count", 32'(err_count), 32'(de.ec));
                check("busy_at_done", 32'(busy), 32'd1);
                check("done_with_pop", 32'(cmd_rd_en), 32'd1);
                busy_drop_chk = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_count < target && k < budget) begin
            step();
            k++;
        end
        check("done_reached", 32'(done_count >= target), 32'd1);
    endtask

    task automatic wait_valid(input int target, input int budget);
        int k = 0;
        while (valid_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("valid_reached", 32'(valid_count >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        int vc;
        int k;
        rst   = 1'b0;
        start = 1'b1;
        fifo_q.push_back(32'h0100_1234);

        // Reset held with start high and a word waiting: everything quiet.
        repeat (3) begin
            @(negedge clk);
            check("reset_strobes", {28'h0, cmd_rd_en, ff_valid, busy, done}, 32'h0);
            check("reset_color", 32'(ff_color), 32'h0);
            check("reset_base", ff_frame_base, 32'h0);
            check("reset_counts", {8'h0, fill_count, err_count}, 32'h0);
        end
        step();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset_busy", 32'(busy), 32'd0);
        check("idle_after_reset_pops", 32'(pop_count), 32'd0);
        step();
        fifo_q.delete();

        // SETBASE, base word, FILL, STOP with a 20-cycle filler busy period.
        fifo_q.push_back(32'h0200_0000);
        fifo_q.push_back(32'h1040_0000);
        fifo_q.push_back(32'h0100_FF00);
        fifo_q.push_back(32'h0000_0000);
        sb.push_back('{24'h00FF00, 32'h1040_0000, 1});
        dq.push_back('{16'd1, 8'd0});
        step();
        start = 1'b1;
        @(negedge clk);
        check("busy_in_start_cycle", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        check("first_pop_after_start", 32'(cmd_rd_en), 32'd1);
        wait_done(1, 200);
        step();
        check("fill_count_seq1", 32'(fill_count), 32'd1);

        // Empty FIFO gap between two FILL commands.
        fifo_q.push_back(32'h0112_3456);
        sb.push_back('{24'h123456, 32'h1040_0000, 1});
        pulse_start();
        k = 0;
        while (!(valid_count >= 2 && ff_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("first_fill_complete", 32'(k < 100), 32'd1);
        step();
        pc = pop_count;
        vc = valid_count;
        repeat (10) step();
        check("gap_pops", 32'(pop_count), 32'(pc));
        check("gap_valids", 32'(valid_count), 32'(vc));
        fifo_q.push_back(32'h01AB_CDEF);
        fifo_q.push_back(32'h0000_0000);
        sb.push_back('{24'hABCDEF, 32'h1040_0000, 1});
        dq.push_back('{16'd2, 8'd0});
        @(negedge clk);
        check("resume_after_gap", 32'(cmd_rd_en), 32'd1);
        wait_done(2, 200);

        // Filler not ready for 5 cycles on entry to ISSUE.
        stall_req = 1'b1;
        fifo_q.push_back(32'h0100_0ABC);
        fifo_q.push_back(32'h0000_0000);
        sb.push_back('{24'h000ABC, 32'h1040_0000, 6});
        dq.push_back('{16'd1, 8'd0});
        pulse_start();
        wait_done(3, 200);

        // 300 unknown opcodes saturate the error counter.
        for (int i = 0; i < 300; i++) fifo_q.push_back(32'h7F00_0000 | 32'(i));
        fifo_q.push_back(32'h0000_0000);
        dq.push_back('{16'd0, 8'd255});
        pulse_start();
        wait_done(4, 1000);
        step();
        check("err_saturated", 32'(err_count), 32'd255);

        // start during WAIT_HI is ignored.
        fifo_q.push_back(32'h01C0_FFEE);
        fifo_q.push_back(32'h0000_0000);
        sb.push_back('{24'hC0FFEE, 32'h1040_0000, 1});
        dq.push_back('{16'd1, 8'd0});
        pulse_start();
        wait_valid(valid_count + 1, 50);
        repeat (5) step();
        pulse_start();
        @(negedge clk);
        check("start_ignored_busy", 32'(busy), 32'd1);
        check("start_ignored_fill_count", 32'(fill_count), 32'd1);
        check("start_ignored_err_count", 32'(err_count), 32'd0);
        wait_done(5, 200);

        repeat (3) step();
        check("fill_scoreboard_drained", 32'(sb.size()), 32'd0);
        check("done_scoreboard_drained", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
